// File: rtl/forward_scoreboard_pkg.sv
// Shared forwarding macros and the lane/stage code helper for the forward scoreboard.
// Forward code layout: 0 = no forward, odd codes = EX/MEM of a lane, even codes = MEM/WB of a lane.
`ifndef FORWARD_SCOREBOARD_DEFINES
`define FORWARD_SCOREBOARD_DEFINES
`define NUM_REGISTERS_LOG2 5
`define FORWARD_BITS(lanes) $clog2(2*(lanes)+1)
`define NO_FORWARD 0
`define FWD_CODE(lane, stage) (1 + 2*(lane) + (stage))
`endif

package forward_scoreboard_pkg;

    typedef enum logic {
        STAGE_EX_MEM = 1'b0,
        STAGE_MEM_WB = 1'b1
    } fwd_stage_e;

    function automatic int fwd_code(input int lane, input fwd_stage_e stage);
        return `FWD_CODE(lane, int'(stage));
    endfunction

endpackage

// File: rtl/forward_scoreboard_select.sv
// Per-operand forward selector: youngest producer wins (EX/MEM over MEM/WB,
// higher lane over lower lane within a stage).
module forward_select
    import forward_scoreboard_pkg::*;
#(
    parameter int LANES = 2,
    parameter int REG_W = `NUM_REGISTERS_LOG2,
    parameter int FB    = `FORWARD_BITS(LANES)
) (
    input  logic [REG_W-1:0]       src,
    input  logic [LANES*REG_W-1:0] ex_mem_rd,
    input  logic [LANES-1:0]       ex_mem_reg_write,
    input  logic [LANES*REG_W-1:0] mem_wb_rd,
    input  logic [LANES-1:0]       mem_wb_reg_write,
    output logic [FB-1:0]          sel
);

    // Later assignments override earlier ones, so the scan order encodes the priority.
    always_comb begin
        sel = FB'(`NO_FORWARD);
        if (src != '0) begin
            for (int l = 0; l < LANES; l++) begin
                if (mem_wb_reg_write[l] && (mem_wb_rd[l*REG_W +: REG_W] == src)) begin
                    sel = FB'(fwd_code(l, STAGE_MEM_WB));
                end
            end
            for (int l = 0; l < LANES; l++) begin
                if (ex_mem_reg_write[l] && (ex_mem_rd[l*REG_W +: REG_W] == src)) begin
                    sel = FB'(fwd_code(l, STAGE_EX_MEM));
                end
            end
        end
    end

endmodule

// File: rtl/forward_scoreboard.sv
// Multi-lane forwarding unit with a per-register latency scoreboard that stalls
// ID/EX while any source operand waits on an in-flight multi-cycle result.
module forward_scoreboard
    import forward_scoreboard_pkg::*;
#(
    parameter  int LANES         = 2,
    parameter  int MAX_LAT       = 8,
    parameter  int REG_W         = `NUM_REGISTERS_LOG2,
    localparam int LAT_W         = $clog2(MAX_LAT + 1),
    localparam int FB            = `FORWARD_BITS(LANES),
    localparam int NUM_REGISTERS = 1 << REG_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LANES*REG_W-1:0] id_ex_rs,
    input  logic [LANES*REG_W-1:0] id_ex_rt,
    input  logic [LANES*REG_W-1:0] ex_mem_rd,
    input  logic [LANES*REG_W-1:0] mem_wb_rd,
    input  logic [LANES-1:0]       ex_mem_reg_write,
    input  logic [LANES-1:0]       mem_wb_reg_write,
    input  logic [LANES-1:0]       issue_valid,
    input  logic [LANES*REG_W-1:0] issue_rd,
    input  logic [LANES*LAT_W-1:0] issue_lat,
    input  logic                   flush,
    output logic [LANES*FB-1:0]    forward_a,
    output logic [LANES*FB-1:0]    forward_b,
    output logic                   stall,
    output logic [31:0]            stall_cycles
);

    for (genvar l = 0; l < LANES; l++) begin : g_fwd
        forward_select #(.LANES(LANES), .REG_W(REG_W), .FB(FB)) u_sel_a (
            .src              (id_ex_rs[l*REG_W +: REG_W]),
            .ex_mem_rd        (ex_mem_rd),
            .ex_mem_reg_write (ex_mem_reg_write),
            .mem_wb_rd        (mem_wb_rd),
            .mem_wb_reg_write (mem_wb_reg_write),
            .sel              (forward_a[l*FB +: FB])
        );
        forward_select #(.LANES(LANES), .REG_W(REG_W), .FB(FB)) u_sel_b (
            .src              (id_ex_rt[l*REG_W +: REG_W]),
            .ex_mem_rd        (ex_mem_rd),
            .ex_mem_reg_write (ex_mem_reg_write),
            .mem_wb_rd        (mem_wb_rd),
            .mem_wb_reg_write (mem_wb_reg_write),
            .sel              (forward_b[l*FB +: FB])
        );
    end

    logic [LANES*LAT_W-1:0]   lat_clamped;
    logic [NUM_REGISTERS-1:0] busy;

    always_comb begin
        lat_clamped = '0;
        for (int l = 0; l < LANES; l++) begin
            if (issue_lat[l*LAT_W +: LAT_W] > LAT_W'(MAX_LAT)) begin
                lat_clamped[l*LAT_W +: LAT_W] = LAT_W'(MAX_LAT);
            end else begin
                lat_clamped[l*LAT_W +: LAT_W] = issue_lat[l*LAT_W +: LAT_W];
            end
        end
    end

    for (genvar r = 0; r < NUM_REGISTERS; r++) begin : g_reg
        logic             load;
        logic [LAT_W-1:0] load_val;
        logic [LAT_W-1:0] cnt_q;

        // Ascending lane scan lets the highest issuing lane set the latency.
        always_comb begin
            load     = 1'b0;
            load_val = '0;
            for (int l = 0; l < LANES; l++) begin
                if (issue_valid[l] && (issue_rd[l*REG_W +: REG_W] != '0) &&
                    (issue_rd[l*REG_W +: REG_W] == REG_W'(r))) begin
                    load     = 1'b1;
                    load_val = lat_clamped[l*LAT_W +: LAT_W];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (flush) begin
                cnt_q <= '0;
            end else if (load && !stall) begin
                cnt_q <= load_val;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end

        assign busy[r] = (cnt_q != '0);
    end

    always_comb begin
        stall = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            if ((id_ex_rs[l*REG_W +: REG_W] != '0) && busy[id_ex_rs[l*REG_W +: REG_W]]) begin
                stall = 1'b1;
            end
            if ((id_ex_rt[l*REG_W +: REG_W] != '0) && busy[id_ex_rt[l*REG_W +: REG_W]]) begin
                stall = 1'b1;
            end
        end
    end

    // Performance counter survives flush; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed bench for forward_scoreboard: table of forwarding vectors plus
// hand-written stall, clamp, flush and reset sequences.
module tb_forward_scoreboard;

    localparam int LANES   = 2;
    localparam int MAX_LAT = 8;
    localparam int REG_W   = 5;
    localparam int LAT_W   = 4;
    localparam int FB      = 3;

    logic                   clk;
    logic                   rst_n;
    logic [LANES*REG_W-1:0] id_ex_rs;
    logic [LANES*REG_W-1:0] id_ex_rt;
    logic [LANES*REG_W-1:0] ex_mem_rd;
    logic [LANES*REG_W-1:0] mem_wb_rd;
    logic [LANES-1:0]       ex_mem_reg_write;
    logic [LANES-1:0]       mem_wb_reg_write;
    logic [LANES-1:0]       issue_valid;
    logic [LANES*REG_W-1:0] issue_rd;
    logic [LANES*LAT_W-1:0] issue_lat;
    logic                   flush;
    logic [LANES*FB-1:0]    forward_a;
    logic [LANES*FB-1:0]    forward_b;
    logic                   stall;
    logic [31:0]            stall_cycles;

    forward_scoreboard #(.LANES(LANES), .MAX_LAT(MAX_LAT), .REG_W(REG_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_ex_rs         (id_ex_rs),
        .id_ex_rt         (id_ex_rt),
        .ex_mem_rd        (ex_mem_rd),
        .mem_wb_rd        (mem_wb_rd),
        .ex_mem_reg_write (ex_mem_reg_write),
        .mem_wb_reg_write (mem_wb_reg_write),
        .issue_valid      (issue_valid),
        .issue_rd         (issue_rd),
        .issue_lat        (issue_lat),
        .flush            (flush),
        .forward_a        (forward_a),
        .forward_b        (forward_b),
        .stall            (stall),
        .stall_cycles     (stall_cycles)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    // Scoreboard compare
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_issue();
        issue_valid = '0;
        issue_rd    = '0;
        issue_lat   = '0;
    endtask

    task automatic clear_all();
        id_ex_rs         = '0;
        id_ex_rt         = '0;
        ex_mem_rd        = '0;
        mem_wb_rd        = '0;
        ex_mem_reg_write = '0;
        mem_wb_reg_write = '0;
        flush            = 1'b0;
        clear_issue();
    endtask

    task automatic set_src(input int l, input int rs, input int rt);
        id_ex_rs[l*REG_W +: REG_W] = REG_W'(rs);
        id_ex_rt[l*REG_W +: REG_W] = REG_W'(rt);
    endtask

    task automatic issue(input int l, input int rd, input int lat);
        issue_valid[l]               = 1'b1;
        issue_rd[l*REG_W +: REG_W]   = REG_W'(rd);
        issue_lat[l*LAT_W +: LAT_W]  = LAT_W'(lat);
    endtask

    // Checks the queued stall profile one cycle per entry, starting before the issuing edge.
    task automatic run_stall_profile(input string name, input int n);
        exp_q.delete();
        exp_q.push_back(32'd0);
        for (int i = 0; i < n; i++) exp_q.push_back(32'd1);
        exp_q.push_back(32'd0);
        while (exp_q.size() > 0) begin
            check(name, {31'b0, stall}, exp_q.pop_front());
            step();
            clear_issue();
        end
    endtask

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] ex0;
        logic [4:0] ex1;
        logic [1:0] ex_we;
        logic [4:0] wb0;
        logic [4:0] wb1;
        logic [1:0] wb_we;
        logic [2:0] exp_a;
        logic [2:0] exp_b;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{5'd5,  5'd0,  5'd5, 5'd0,  2'b01, 5'd0,  5'd5,  2'b10, 3'd1, 3'd0};
        vecs[1] = '{5'd3,  5'd7,  5'd7, 5'd7,  2'b11, 5'd0,  5'd0,  2'b00, 3'd0, 3'd3};
        vecs[2] = '{5'd3,  5'd7,  5'd7, 5'd7,  2'b00, 5'd0,  5'd0,  2'b00, 3'd0, 3'd0};
        vecs[3] = '{5'd0,  5'd0,  5'd0, 5'd0,  2'b11, 5'd0,  5'd0,  2'b11, 3'd0, 3'd0};
        vecs[4] = '{5'd10, 5'd10, 5'd0, 5'd0,  2'b00, 5'd10, 5'd10, 2'b11, 3'd4, 3'd4};
        vecs[5] = '{5'd12, 5'd13, 5'd0, 5'd12, 2'b10, 5'd12, 5'd13, 2'b11, 3'd3, 3'd4};
        vecs[6] = '{5'd8,  5'd20, 5'd8, 5'd20, 2'b01, 5'd0,  5'd8,  2'b10, 3'd1, 3'd0};
        vecs[7] = '{5'd31, 5'd31, 5'd0, 5'd0,  2'b00, 5'd31, 5'd0,  2'b01, 3'd2, 3'd2};
        vecs[8] = '{5'd6,  5'd9,  5'd9, 5'd0,  2'b11, 5'd6,  5'd6,  2'b11, 3'd4, 3'd1};

        rst_n = 1'b0;
        clear_all();
        #12;
        check("reset_stall", {31'b0, stall}, 32'd0);
        check("reset_stall_cycles", stall_cycles, 32'd0);
        check("reset_forward_a", {26'b0, forward_a}, 32'd0);
        #10 rst_n = 1'b1;
        step();

        // Combinational forwarding table, same operands on both lanes
        foreach (vecs[i]) begin
            clear_all();
            for (int l = 0; l < LANES; l++) set_src(l, vecs[i].rs, vecs[i].rt);
            ex_mem_rd        = {vecs[i].ex1, vecs[i].ex0};
            ex_mem_reg_write = vecs[i].ex_we;
            mem_wb_rd        = {vecs[i].wb1, vecs[i].wb0};
            mem_wb_reg_write = vecs[i].wb_we;
            #1;
            for (int l = 0; l < LANES; l++) begin
                check($sformatf("vec%0d_lane%0d_fwd_a", i, l), {29'b0, forward_a[l*FB +: FB]}, {29'b0, vecs[i].exp_a});
                check($sformatf("vec%0d_lane%0d_fwd_b", i, l), {29'b0, forward_b[l*FB +: FB]}, {29'b0, vecs[i].exp_b});
            end
            check($sformatf("vec%0d_stall", i), {31'b0, stall}, 32'd0);
        end

        // rd=9 lat=3 on lane 0, rs=9 held
        clear_all();
        step();
        set_src(0, 9, 0);
        issue(0, 9, 3);
        run_stall_profile("lat3_stall", 3);
        check("lat3_stall_cycles", stall_cycles, 32'd3);

        // Two lanes to rd=4: lane 1's latency of 5 wins; watched through rt on lane 1
        clear_all();
        set_src(1, 0, 4);
        issue(0, 4, 2);
        issue(1, 4, 5);
        run_stall_profile("same_rd_stall", 5);
        check("same_rd_stall_cycles", stall_cycles, 32'd8);

        // Latency 15 clamps to 8; an issue presented during the stall is dropped
        clear_all();
        set_src(1, 11, 0);
        issue(1, 11, 15);
        check("clamp_pre", {31'b0, stall}, 32'd0);
        step();
        clear_issue();
        issue(0, 12, 3);
        for (int i = 0; i < MAX_LAT; i++) begin
            check($sformatf("clamp_stall_c%0d", i), {31'b0, stall}, 32'd1);
            step();
            clear_issue();
        end
        check("clamp_release", {31'b0, stall}, 32'd0);
        set_src(1, 12, 0);
        #1;
        check("ignored_issue", {31'b0, stall}, 32'd0);
        issue(0, 13, 0);
        step();
        clear_issue();
        set_src(0, 13, 13);
        #1;
        check("lat0_no_stall", {31'b0, stall}, 32'd0);
        check("clamp_stall_cycles", stall_cycles, 32'd16);

        // Flush after two stalled cycles; a simultaneous issue is discarded
        clear_all();
        set_src(0, 6, 0);
        issue(0, 6, 8);
        step();
        clear_issue();
        check("flush_stall_c0", {31'b0, stall}, 32'd1);
        step();
        check("flush_stall_c1", {31'b0, stall}, 32'd1);
        flush = 1'b1;
        issue(1, 14, 5);
        step();
        flush = 1'b0;
        clear_issue();
        check("flush_drop", {31'b0, stall}, 32'd0);
        set_src(1, 0, 14);
        #1;
        check("flush_discard_issue", {31'b0, stall}, 32'd0);
        check("flush_keeps_stall_cycles", stall_cycles, 32'd18);

        // Reset pulse mid-countdown clears state without a clock edge
        clear_all();
        set_src(0, 6, 0);
        issue(0, 6, 5);
        step();
        clear_issue();
        check("rst_pre_stall", {31'b0, stall}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("rst_async_stall", {31'b0, stall}, 32'd0);
        check("rst_async_stall_cycles", stall_cycles, 32'd0);
        #2 rst_n = 1'b1;
        step();
        check("rst_after_stall", {31'b0, stall}, 32'd0);
        check("rst_after_stall_cycles", stall_cycles, 32'd0);

        // Final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/forward_scoreboard.md
FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 Parameter LANES, default 2: number of issue lanes; lane 0 is oldest in program order.
REQ-002 Parameter MAX_LAT, default 8: largest multi-cycle latency accepted; LAT_W = clog2(MAX_LAT+1).
REQ-003 Parameter REG_W, default `NUM_REGISTERS_LOG2: register index width.
REQ-004 clk  in  1  single clock; every flop is on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 id_ex_rs, id_ex_rt  in  LANES*REG_W  source indices per lane.
REQ-007 ex_mem_rd, mem_wb_rd  in  LANES*REG_W  destination per lane per stage.
REQ-008 ex_mem_reg_write, mem_wb_reg_write  in  LANES  write-enable per lane per stage.
REQ-009 issue_valid  in  LANES  multi-cycle op enters EX this cycle.
REQ-010 issue_rd  in  LANES*REG_W  and issue_lat  in  LANES*LAT_W: destination and cycles until the result is forwardable.
REQ-011 flush  in  1  pipeline flush; clears all pending state.
REQ-012 forward_a, forward_b  out  LANES*`FORWARD_BITS  per-lane forward select.
REQ-013 stall  out  1  hold ID/EX; stall_cycles  out  32  saturating count of stalled cycles.

Function
REQ-014 Forward code: 0 = `NO_FORWARD; 1+2*l = EX/MEM of lane l; 2+2*l = MEM/WB of lane l; `FORWARD_BITS = clog2(2*LANES+1).
REQ-015 Source index 0 never forwards and never stalls.
REQ-016 Forward priority is youngest producer first: any EX/MEM match beats any MEM/WB match; within a stage, the higher lane index wins.
REQ-017 A forward match requires the producer's reg_write bit to be set and rd equal to the source index.
REQ-018 forward_a and forward_b are combinational from their inputs, with zero-cycle latency.
REQ-019 Scoreboard: one LAT_W down-counter per register, busy[r] = (cnt[r] != 0).
REQ-020 Each cycle, every nonzero counter decrements by 1 and saturates at 0.
REQ-021 An issue with issue_valid[l]=1, stall=0 and issue_rd != 0 loads cnt[issue_rd] with issue_lat; the load overrides the decrement in the same cycle.
REQ-022 When two lanes issue to the same rd in the same cycle, the higher lane's issue_lat is loaded.
REQ-023 issue_lat of 0 loads 0, so no stall results; issue_lat > MAX_LAT is clamped to MAX_LAT.
REQ-024 Issues presented while stall=1 are ignored.
REQ-025 stall = OR over lanes of busy[id_ex_rs] or busy[id_ex_rt], with index 0 excluded.
REQ-026 stall is combinational from the registered counters and does not depend on the forward result.
REQ-027 Flush zeroes every counter on the next edge; a simultaneous issue is discarded.
REQ-028 stall_cycles increments on each edge where stall=1, holds at 2^32-1, and is not cleared by flush.

Reset
REQ-029 While rst_n=0, all counters are 0, stall=0 and stall_cycles=0, asynchronously.
REQ-030 Outputs are valid in the first cycle after rst_n deasserts.
REQ-031 Reset asserted mid-countdown discards all pending entries.

Structure
REQ-032 The shared defines file holds FORWARD_BITS, NO_FORWARD, the lane/stage code formula and NUM_REGISTERS_LOG2.
REQ-033 One sub-module, forward_select, performs the per-operand priority match and is instantiated 2*LANES times.
REQ-034 The scoreboard counters and stall logic live in the top module, generated over NUM_REGISTERS.

Verification
REQ-035 rs=5, ex_mem lane0 rd=5 we=1 and mem_wb lane1 rd=5 we=1 -> forward_a=1.
REQ-036 rt=7, ex_mem lane0 and lane1 both rd=7 we=1 -> forward_b=3; with both we=0 -> forward_b=0.
REQ-037 rs=0 with every rd=0 we=1 -> forward=0 and stall=0.
REQ-038 issue lane0 rd=9 lat=3, then rs=9 held -> stall=1 for exactly 3 cycles, then 0; stall_cycles=3.
REQ-039 lane0 rd=4 lat=2 and lane1 rd=4 lat=5 in the same cycle -> stall on rs=4 for 5 cycles.
REQ-040 issue rd=6 lat=8, flush after 2 cycles -> stall drops next cycle; rst_n pulse mid-count -> stall=0 immediately.
